alu_mc: RTL and testbench

//  Parametrised successor ALU for the CPU datapath: WIDTH-bit add/sub with
//  per-nibble decimal (BCD) correction, shifts/rotates, inc/dec, logic ops,
//  and iterative unsigned multiply/divide. Single-cycle ops and multi-cycle
//  MUL/DIV share one start/busy/done handshake. RDY stalls the whole block.
//  All results and flags are registered.

---
 rtl/alu_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit ALU with BCD add/sub, shifts, logic ops and iterative MUL/DIV.
// Single-cycle ops and multi-cycle MUL/DIV share one start/busy/done handshake.
// RDY=0 freezes every register.
module alu_mc #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DECIMAL_EN = 1,
    parameter int unsigned MULDIV_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RDY,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    input  logic             CI,
    input  logic             BCD,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             HC,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand / divisor
    logic [WIDTH:0]   acc_q, acc_d;     // product high part / remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / quotient
    logic             dz_q, dz_d;       // divide-by-zero seen at launch
    logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
    logic             co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, hc_q, hc_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             is_mul, is_div, dec_en, sub_op;
    logic [WIDTH-1:0] addb, bin_sum, sc_out;
    logic             sc_co, sc_v, sc_hc, carry;
    logic [4:0]       sum5;

    logic [WIDTH:0]   mul_sum, mul_acc_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_sh, div_rem_n;
    logic [WIDTH+1:0] div_tr;
    logic [WIDTH-1:0] div_q_n;

    assign is_mul = (MULDIV_EN != 0) && (op == 4'b1100);
    assign is_div = (MULDIV_EN != 0) && (op == 4'b1101);
    assign dec_en = (DECIMAL_EN != 0) && BCD;
    assign sub_op = op[0];

    // One shift-add multiply step
    assign mul_sum   = lo_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
    assign mul_acc_n = {1'b0, mul_sum[WIDTH:1]};
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // One restoring-divide step; the extra top bit of div_tr is the borrow
    assign div_sh    = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_tr    = {1'b0, div_sh} - {2'b00, opb_q};
    assign div_rem_n = div_tr[WIDTH+1] ? div_sh : div_tr[WIDTH:0];
    assign div_q_n   = {lo_q[WIDTH-2:0], ~div_tr[WIDTH+1]};

    // Single-cycle result and flags, nibble-serial carry chain for ADD/SUB
    always_comb begin
        sc_out  = AI;
        sc_co   = 1'b0;
        sc_v    = 1'b0;
        sc_hc   = 1'b0;
        carry   = 1'b0;
        sum5    = '0;
        addb    = sub_op ? ~BI : BI;
        bin_sum = AI + addb + WIDTH'(CI);
        case (op)
            4'b0000, 4'b0001: begin
                carry = CI;
                for (int unsigned i = 0; i < NIB; i++) begin
                    sum5 = {1'b0, AI[4*i +: 4]} + {1'b0, addb[4*i +: 4]} + {4'b0000, carry};
                    if (dec_en && !sub_op) begin
                        if (sum5 > 5'd9) begin
                            sum5  = sum5 + 5'd6;
                            carry = 1'b1;
                        end else begin
                            carry = 1'b0;
                        end
                    end else if (dec_en && sub_op) begin
                        carry = sum5[4];
                        if (!carry) sum5 = sum5 - 5'd6;
                    end else begin
                        carry = sum5[4];
                    end
                    sc_out[4*i +: 4] = sum5[3:0];
                    if (i == 0) sc_hc = carry;
                end
                sc_co = carry;
                sc_v  = (AI[WIDTH-1] == addb[WIDTH-1]) && (bin_sum[WIDTH-1] != AI[WIDTH-1]);
            end
            4'b0010: begin sc_out = {AI[WIDTH-2:0], 1'b0}; sc_co = AI[WIDTH-1]; end
            4'b0011: begin sc_out = {AI[WIDTH-2:0], CI};   sc_co = AI[WIDTH-1]; end
            4'b0100: begin sc_out = {1'b0, AI[WIDTH-1:1]}; sc_co = AI[0];       end
            4'b0101: begin sc_out = {CI, AI[WIDTH-1:1]};   sc_co = AI[0];       end
            4'b0110: sc_out = AI + WIDTH'(1);
            4'b0111: sc_out = AI - WIDTH'(1);
            4'b1000: sc_out = AI | BI;
            4'b1001: sc_out = AI & BI;
            4'b1010: sc_out = AI ^ BI;
            default: sc_out = AI;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= S_IDLE;
        else if (RDY) state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && is_mul)      state_d = S_MUL;
                else if (start && is_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d  = cnt_q;
        opb_d  = opb_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        out_d  = out_q;
        hi_d   = hi_q;
        co_d   = co_q;
        v_d    = v_q;
        z_d    = z_q;
        n_d    = n_q;
        hc_d   = hc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (is_mul || is_div)) begin
                    opb_d  = BI;
                    lo_d   = AI;
                    acc_d  = '0;
                    dz_d   = (BI == '0);
                    cnt_d  = CW'(WIDTH - 1);
                    busy_d = 1'b1;
                end else if (start) begin
                    out_d  = sc_out;
                    hi_d   = '0;
                    co_d   = sc_co;
                    v_d    = sc_v;
                    hc_d   = sc_hc;
                    z_d    = (sc_out == '0);
                    n_d    = sc_out[WIDTH-1];
                    done_d = 1'b1;
                end
            end
            S_MUL: begin
                acc_d = mul_acc_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    out_d  = mul_lo_n;
                    hi_d   = mul_acc_n[WIDTH-1:0];
                    co_d   = 1'b0;
                    v_d    = 1'b0;
                    hc_d   = 1'b0;
                    z_d    = ({mul_acc_n[WIDTH-1:0], mul_lo_n} == '0);
                    n_d    = mul_acc_n[WIDTH-1];
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = div_rem_n;
                lo_d  = div_q_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    out_d  = div_q_n;
                    hi_d   = div_rem_n[WIDTH-1:0];
                    co_d   = 1'b0;
                    v_d    = dz_q;
                    hc_d   = 1'b0;
                    z_d    = (div_q_n == '0);
                    n_d    = div_q_n[WIDTH-1];
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers, frozen while RDY=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
            out_q  <= '0;
            hi_q   <= '0;
            co_q   <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b1;
            n_q    <= 1'b0;
            hc_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (RDY) begin
            cnt_q  <= cnt_d;
            opb_q  <= opb_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            out_q  <= out_d;
            hi_q   <= hi_d;
            co_q   <= co_d;
            v_q    <= v_d;
            z_q    <= z_d;
            n_q    <= n_d;
            hc_q   <= hc_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign OUT    = out_q;
    assign OUT_HI = hi_q;
    assign CO     = co_q;
    assign V      = v_q;
    assign Z      = z_q;
    assign N      = n_q;
    assign HC     = hc_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8 and WIDTH=16.
module tb_alu_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] out;
        logic [15:0] hi;
        logic [4:0]  fl;   // {co,v,z,n,hc}
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   total = 0;
    int   bad   = 0;
    logic seen8 = 1'b0;
    logic seen16 = 1'b0;

    // 8-bit instance
    logic       rdy8 = 1'b1, start8 = 1'b0, ci8 = 1'b0, bcd8 = 1'b0;
    logic [3:0] op8 = 4'h0;
    logic [7:0] ai8 = 8'h00, bi8 = 8'h00;
    logic [7:0] out8, hi8;
    logic       co8, v8, z8, n8, hc8, busy8, done8;

    alu_mc #(.WIDTH(8), .DECIMAL_EN(1), .MULDIV_EN(1)) u_alu8 (
        .clk(clk), .rst_n(rst_n), .RDY(rdy8), .start(start8), .op(op8),
        .AI(ai8), .BI(bi8), .CI(ci8), .BCD(bcd8),
        .OUT(out8), .OUT_HI(hi8), .CO(co8), .V(v8), .Z(z8), .N(n8), .HC(hc8),
        .busy(busy8), .done(done8)
    );

    // 16-bit instance
    logic        rdy16 = 1'b1, start16 = 1'b0, ci16 = 1'b0, bcd16 = 1'b0;
    logic [3:0]  op16 = 4'h0;
    logic [15:0] ai16 = 16'h0, bi16 = 16'h0;
    logic [15:0] out16, hi16;
    logic        co16, v16, z16, n16, hc16, busy16, done16;

    alu_mc #(.WIDTH(16), .DECIMAL_EN(1), .MULDIV_EN(1)) u_alu16 (
        .clk(clk), .rst_n(rst_n), .RDY(rdy16), .start(start16), .op(op16),
        .AI(ai16), .BI(bi16), .CI(ci16), .BCD(bcd16),
        .OUT(out16), .OUT_HI(hi16), .CO(co16), .V(v16), .Z(z16), .N(n16), .HC(hc16),
        .busy(busy16), .done(done16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitors: one pop per done pulse (a stretched pulse counts once)
    always @(posedge clk) begin
        if (rdy8) seen8 = 1'b0;
        if (rdy16) seen16 = 1'b0;
    end

    always @(negedge clk) begin
        if (done8 && !seen8) begin
            seen8 = 1'b1;
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_unexpected actual=done required=no_done");
            end else begin
                e8 = q8.pop_front();
                chk({e8.nm, " {out,hi,co,v,z,n,hc}"},
                    64'({16'(out8), 16'(hi8), co8, v8, z8, n8, hc8}),
                    64'({e8.out, e8.hi, e8.fl}));
            end
        end
        if (done16 && !seen16) begin
            seen16 = 1'b1;
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL done16_unexpected actual=done required=no_done");
            end else begin
                e16 = q16.pop_front();
                chk({e16.nm, " {out,hi,co,v,z,n,hc}"},
                    64'({out16, hi16, co16, v16, z16, n16, hc16}),
                    64'({e16.out, e16.hi, e16.fl}));
            end
        end
    end

    // Launch one 8-bit op; lat = edges after the launch edge until done is seen
    task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d, input logic [7:0] eo, input logic [7:0] eh,
                        input logic [4:0] ef, input int lat, input int poke_at = -1,
                        input int stall_at = -1, input int stall_len = 0);
        int k;
        int bsy;
        exp_t e;
        e.nm = nm; e.out = 16'(eo); e.hi = 16'(eh); e.fl = ef;
        q8.push_back(e);
        op8 = o; ai8 = a; bi8 = b; ci8 = c; bcd8 = d; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        k = 0; bsy = 0;
        while (!done8 && k < 40) begin
            if (busy8) bsy++;
            if (k == poke_at) begin start8 = 1'b1; op8 = 4'b0000; ai8 = 8'hFF; end
            if (k == poke_at + 1) start8 = 1'b0;
            if (k == stall_at) rdy8 = 1'b0;
            if (stall_at >= 0 && k == stall_at + stall_len) rdy8 = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        start8 = 1'b0;
        rdy8 = 1'b1;
        if (!done8) begin
            total++; bad++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
        end else begin
            chk({nm, " latency"}, 64'(k), 64'(lat));
            chk({nm, " busy_cycles"}, 64'(bsy), 64'(lat));
        end
    endtask

    task automatic run16(input string nm, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic d, input logic [15:0] eo, input logic [15:0] eh,
                         input logic [4:0] ef, input int lat);
        int k;
        exp_t e;
        e.nm = nm; e.out = eo; e.hi = eh; e.fl = ef;
        q16.push_back(e);
        op16 = o; ai16 = a; bi16 = b; ci16 = c; bcd16 = d; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        k = 0;
        while (!done16 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done16) begin
            total++; bad++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
        end else begin
            chk({nm, " latency"}, 64'(k), 64'(lat));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset8 {out,hi,co,v,z,n,hc,busy,done}",
            64'({out8, hi8, co8, v8, z8, n8, hc8, busy8, done8}), 64'({8'h00, 8'h00, 7'b0010000}));
        chk("reset16 {out,z,busy,done}", 64'({out16, z16, busy16, done16}), 64'({16'h0, 3'b100}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-cycle ops; flags are {co,v,z,n,hc}
        run8("add_bcd_45_38", 4'b0000, 8'h45, 8'h38, 1'b0, 1'b1, 8'h83, 8'h00, 5'b00011, 0);
        run8("sub_bcd_42_17", 4'b0001, 8'h42, 8'h17, 1'b1, 1'b1, 8'h25, 8'h00, 5'b10000, 0);
        run8("sub_50_b0",     4'b0001, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 8'h00, 5'b01011, 0);
        run8("ror_01",        4'b0101, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 5'b10010, 0);
        run8("add_ff_01",     4'b0000, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 5'b10101, 0);
        run8("add_7f_01",     4'b0000, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h00, 5'b01011, 0);
        run8("add_bcd_99_01", 4'b0000, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 5'b10101, 0);
        run8("asl_81",        4'b0010, 8'h81, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 5'b10000, 0);
        run8("rol_81",        4'b0011, 8'h81, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00, 5'b10000, 0);
        run8("lsr_81",        4'b0100, 8'h81, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 5'b10000, 0);
        run8("inc_ff",        4'b0110, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 5'b00100, 0);
        run8("dec_00",        4'b0111, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 5'b00010, 0);
        run8("or_0f_30",      4'b1000, 8'h0F, 8'h30, 1'b0, 1'b0, 8'h3F, 8'h00, 5'b00000, 0);
        run8("and_f0_3c",     4'b1001, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00, 5'b00000, 0);
        run8("xor_aa_ff",     4'b1010, 8'hAA, 8'hFF, 1'b0, 1'b0, 8'h55, 8'h00, 5'b00000, 0);
        run8("pass_5a",       4'b1011, 8'h5A, 8'h11, 1'b1, 1'b0, 8'h5A, 8'h00, 5'b00000, 0);
        run8("pass_1111_c3",  4'b1111, 8'hC3, 8'h11, 1'b1, 1'b0, 8'hC3, 8'h00, 5'b00010, 0);

        // done pulse stretches while RDY=0
        run8("inc_41",        4'b0110, 8'h41, 8'h00, 1'b0, 1'b0, 8'h42, 8'h00, 5'b00000, 0);
        rdy8 = 1'b0;
        @(posedge clk); #1;
        chk("done_stretch_rdy0", 64'(done8), 64'(1));
        rdy8 = 1'b1;
        @(posedge clk); #1;
        chk("done_drop_rdy1", 64'(done8), 64'(0));

        // multi-cycle ops
        run8("mul_ff_ff",  4'b1100, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01, 8'hFE, 5'b00010, 8, 3);
        run8("div_c8_07",  4'b1101, 8'hC8, 8'h07, 1'b0, 1'b0, 8'h1C, 8'h04, 5'b00000, 8);
        run8("div_33_00",  4'b1101, 8'h33, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h33, 5'b01010, 8);
        run8("mul_00_37",  4'b1100, 8'h00, 8'h37, 1'b0, 1'b0, 8'h00, 8'h00, 5'b00100, 8);
        run8("mul_12_34_stall", 4'b1100, 8'h12, 8'h34, 1'b0, 1'b0, 8'hA8, 8'h03, 5'b00000, 11, -1, 2, 3);

        // reset in the middle of a DIV
        op8 = 4'b1101; ai8 = 8'hC8; bi8 = 8'h07; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("busy_mid_div", 64'(busy8), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_div {out,z,busy,done}", 64'({out8, z8, busy8, done8}), 64'({8'h00, 3'b100}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run8("add_01_01_after_rst", 4'b0000, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 8'h00, 5'b00000, 0);

        // WIDTH=16
        run16("w16_add_1234_4321", 4'b0000, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 16'h0000, 5'b00000, 0);
        run16("w16_add_bcd_9999_1", 4'b0000, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'h0000, 5'b10101, 0);
        run16("w16_mul_ffff_ffff", 4'b1100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0001, 16'hFFFE, 5'b00010, 16);
        run16("w16_mul_1234_0010", 4'b1100, 16'h1234, 16'h0010, 1'b0, 1'b0, 16'h2340, 16'h0001, 5'b00000, 16);

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", 64'(q8.size()), 64'(0));
        chk("q16_drained", 64'(q16.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
